// File: rtl/byte_axil_bridge.sv
// Byte-stream to AXI4-Lite master bridge.
//
// Executes one decoded read or write command at a time. Write payload bytes are packed
// into 32-bit AXI4-Lite writes with byte strobes. AXI4-Lite read words are unpacked into
// a byte stream. Exactly one AXI transaction is ever in flight.
//
// Ports:
//   clk, reset_n                 system clock, asynchronous active-low reset
//   cmd_valid/ready/write/addr/len  command handshake: direction, start byte address, byte count
//   wr_valid/ready/data          write payload byte stream (into the bridge)
//   rd_valid/ready/data          read data byte stream (out of the bridge)
//   done, err                    one-cycle completion pulse; err=1 if any response was not OKAY
//   m_aw*, m_w*, m_b*            AXI4-Lite write channels (master side)
//   m_ar*, m_r*                  AXI4-Lite read channels (master side)
module byte_axil_bridge (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [15:0] cmd_len,

    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,

    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  rd_data,

    output logic        done,
    output logic        err,

    output logic [31:0] m_awaddr,
    output logic [2:0]  m_awprot,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,

    output logic [31:0] m_araddr,
    output logic [2:0]  m_arprot,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rvalid,
    output logic        m_rready
);

    typedef enum logic [2:0] {
        StIdle,
        StWGather,
        StWIssue,
        StWResp,
        StRIssue,
        StRWait,
        StRStream,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [15:0] remain_q, remain_d;
    logic [31:0] wbuf_q, wbuf_d;
    logic [3:0]  strb_q, strb_d;
    logic        err_acc_q, err_acc_d;
    logic [29:0] word_q, word_d;     // word address of the bytes being gathered
    logic        aw_pend_q, aw_pend_d;
    logic        w_pend_q, w_pend_d;
    logic [31:0] rbuf_q, rbuf_d;

    logic [1:0]  lane;
    logic        aw_fin;
    logic        w_fin;

    assign lane     = addr_q[1:0];
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;
    assign m_awaddr = {word_q, 2'b00};
    assign m_wdata  = wbuf_q;
    assign m_wstrb  = strb_q;
    assign m_araddr = {addr_q[31:2], 2'b00};
    // addr only moves on a stream handshake, so rd_data holds while stalled.
    assign rd_data  = rbuf_q[{lane, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            remain_q  <= '0;
            wbuf_q    <= '0;
            strb_q    <= '0;
            err_acc_q <= 1'b0;
            word_q    <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rbuf_q    <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            wbuf_q    <= wbuf_d;
            strb_q    <= strb_d;
            err_acc_q <= err_acc_d;
            word_q    <= word_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            rbuf_q    <= rbuf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        remain_d  = remain_q;
        wbuf_d    = wbuf_q;
        strb_d    = strb_q;
        err_acc_d = err_acc_q;
        word_d    = word_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        rbuf_d    = rbuf_q;

        cmd_ready = 1'b0;
        wr_ready  = 1'b0;
        rd_valid  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        aw_fin    = 1'b0;
        w_fin     = 1'b0;

        unique case (state_q)
            StIdle: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d    = cmd_addr;
                    remain_d  = cmd_len;
                    err_acc_d = 1'b0;
                    wbuf_d    = '0;
                    strb_d    = '0;
                    if (cmd_len == 16'd0) begin
                        state_d = StDone;
                    end else if (cmd_write) begin
                        state_d = StWGather;
                    end else begin
                        state_d = StRIssue;
                    end
                end
            end

            StWGather: begin
                wr_ready = 1'b1;
                if (wr_valid) begin
                    wbuf_d[{lane, 3'b000} +: 8] = wr_data;
                    strb_d[lane] = 1'b1;
                    word_d       = addr_q[31:2];
                    addr_d       = addr_q + 32'd1;
                    remain_d     = remain_q - 16'd1;
                    if (lane == 2'd3 || remain_q == 16'd1) begin
                        state_d   = StWIssue;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end
                end
            end

            StWIssue: begin
                // AW and W complete independently; leave once both have gone.
                m_awvalid = aw_pend_q;
                m_wvalid  = w_pend_q;
                aw_fin    = !aw_pend_q || m_awready;
                w_fin     = !w_pend_q || m_wready;
                aw_pend_d = aw_pend_q && !m_awready;
                w_pend_d  = w_pend_q && !m_wready;
                if (aw_fin && w_fin) begin
                    state_d = StWResp;
                end
            end

            StWResp: begin
                m_bready = 1'b1;
                if (m_bvalid) begin
                    err_acc_d = err_acc_q | (m_bresp != 2'b00);
                    strb_d    = '0;
                    wbuf_d    = '0;
                    state_d   = (remain_q == 16'd0) ? StDone : StWGather;
                end
            end

            StRIssue: begin
                m_arvalid = 1'b1;
                if (m_arready) begin
                    state_d = StRWait;
                end
            end

            StRWait: begin
                m_rready = 1'b1;
                if (m_rvalid) begin
                    rbuf_d    = m_rdata;
                    err_acc_d = err_acc_q | (m_rresp != 2'b00);
                    state_d   = StRStream;
                end
            end

            StRStream: begin
                rd_valid = 1'b1;
                if (rd_ready) begin
                    addr_d   = addr_q + 32'd1;
                    remain_d = remain_q - 16'd1;
                    if (remain_q == 16'd1) begin
                        state_d = StDone;
                    end else if (lane == 2'd3) begin
                        state_d = StRIssue;
                    end
                end
            end

            StDone: begin
                done    = 1'b1;
                err     = err_acc_q;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_byte_axil_bridge.sv
// Directed bench for byte_axil_bridge with a small AXI4-Lite slave responder.
module tb_byte_axil_bridge;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        done;
    logic        err;
    logic [31:0] m_awaddr;
    logic [2:0]  m_awprot;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic [2:0]  m_arprot;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    int checks;
    int errors;

    // Slave configuration (written by the main sequence only).
    int          aw_wait;
    int          w_wait;
    int          ar_wait;
    logic [1:0]  bresp_cfg;
    logic [1:0]  rresp_cfg;

    // Slave logs (written by the slave process only).
    logic [31:0] aw_log[$];
    logic [31:0] wd_log[$];
    logic [3:0]  ws_log[$];
    logic [31:0] ar_log[$];
    int          valid_cycles;

    byte_axil_bridge dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .done      (done),
        .err       (err),
        .m_awaddr  (m_awaddr),
        .m_awprot  (m_awprot),
        .m_awvalid (m_awvalid),
        .m_awready (m_awready),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wvalid  (m_wvalid),
        .m_wready  (m_wready),
        .m_bresp   (m_bresp),
        .m_bvalid  (m_bvalid),
        .m_bready  (m_bready),
        .m_araddr  (m_araddr),
        .m_arprot  (m_arprot),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    function automatic logic [31:0] rd_mem(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h4433_2211;
            32'h0000_1004: return 32'h8877_6655;
            default:       return 32'hDEAD_BEEF;
        endcase
    endfunction

    // AXI4-Lite slave: samples handshakes at the edge, updates its drives 1 ns later.
    initial begin
        logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
        logic [31:0] aw_a, w_d, ar_a;
        logic [3:0]  w_s;
        logic        got_aw, got_w;
        int          aw_cnt, w_cnt, ar_cnt;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;    m_rresp = 2'b00;
        got_aw = 1'b0; got_w = 1'b0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        valid_cycles = 0;
        forever begin
            @(posedge clk);
            aw_hs = m_awvalid && m_awready;
            w_hs  = m_wvalid && m_wready;
            b_hs  = m_bvalid && m_bready;
            ar_hs = m_arvalid && m_arready;
            r_hs  = m_rvalid && m_rready;
            aw_a  = m_awaddr;
            w_d   = m_wdata;
            w_s   = m_wstrb;
            ar_a  = m_araddr;
            if (m_awvalid || m_wvalid || m_arvalid) valid_cycles++;
            #1;
            if (!reset_n) begin
                m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0;
                m_arready = 1'b0; m_rvalid = 1'b0;
                got_aw = 1'b0; got_w = 1'b0; aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
            end else begin
                if (aw_hs) begin aw_log.push_back(aw_a); got_aw = 1'b1; end
                if (w_hs) begin wd_log.push_back(w_d); ws_log.push_back(w_s); got_w = 1'b1; end
                if (b_hs) begin
                    m_bvalid = 1'b0; got_aw = 1'b0; got_w = 1'b0;
                end else if (got_aw && got_w && !m_bvalid) begin
                    m_bvalid = 1'b1; m_bresp = bresp_cfg;
                end
                if (ar_hs) begin
                    ar_log.push_back(ar_a);
                    m_rvalid = 1'b1; m_rdata = rd_mem(ar_a); m_rresp = rresp_cfg;
                end else if (r_hs) begin
                    m_rvalid = 1'b0;
                end
                if (m_awvalid) begin aw_cnt++; m_awready = (aw_cnt > aw_wait); end
                else begin aw_cnt = 0; m_awready = 1'b0; end
                if (m_wvalid) begin w_cnt++; m_wready = (w_cnt > w_wait); end
                else begin w_cnt = 0; m_wready = 1'b0; end
                if (m_arvalid) begin ar_cnt++; m_arready = (ar_cnt > ar_wait); end
                else begin ar_cnt = 0; m_arready = 1'b0; end
            end
        end
    end

    task automatic issue_cmd(input logic wr, input logic [31:0] a, input logic [15:0] len);
        int t;
        t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_len = len;
        while (!cmd_ready && t < 50) begin @(negedge clk); t++; end
        checks++;
        if (!cmd_ready) begin
            errors++;
            $display("FAIL cmd_accept: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic send_bytes(input logic [31:0] bytes, input int n);
        int t;
        for (int i = 0; i < n; i++) begin
            t = 0;
            @(negedge clk);
            wr_valid = 1'b1; wr_data = bytes[8*i +: 8];
            while (!wr_ready && t < 100) begin @(negedge clk); t++; end
            checks++;
            if (!wr_ready) begin
                errors++;
                $display("FAIL wr_accept byte %0d: wr_ready=%b required 1", i, wr_ready);
            end
            @(posedge clk); #1;
            wr_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output logic e, output int cyc);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!done && cyc < 300);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=%b required 1 within 300 cycles", done);
        end
        e = err;
    endtask

    task automatic read_bytes(input bit rnd, output logic [63:0] got, output int nb,
                              output logic e);
        int         t;
        logic       stall;
        logic [7:0] prev;
        t = 0; nb = 0; got = '0; stall = 1'b0; prev = '0;
        while (t < 400) begin
            @(negedge clk); t++;
            if (done) break;
            if (stall && rd_valid) begin
                checks++;
                if (rd_data !== prev) begin
                    errors++;
                    $display("FAIL rd_stable: rd_data=%h required %h", rd_data, prev);
                end
            end
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rd_valid && rd_ready) begin
                if (nb < 8) got[8*nb +: 8] = rd_data;
                nb++;
                stall = 1'b0;
            end else begin
                stall = rd_valid;
                prev  = rd_data;
            end
        end
        rd_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL read_done_timeout: done=%b required 1", done);
        end
        e = err;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({cmd_ready, wr_ready, rd_valid, done, err, m_awvalid, m_wvalid, m_bready,
             m_arvalid, m_rready} !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 1000000000",
                     {cmd_ready, wr_ready, rd_valid, done, err, m_awvalid, m_wvalid,
                      m_bready, m_arvalid, m_rready});
        end
        checks++;
        if ({m_awprot, m_arprot} !== 6'b0) begin
            errors++;
            $display("FAIL prot_tie: got %b required 000000", {m_awprot, m_arprot});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_len_zero;
        logic e;
        int   cyc;
        int   v0;
        v0 = valid_cycles;
        issue_cmd(1'b1, 32'h0000_0040, 16'd0);
        wait_done(e, cyc);
        checks++;
        if (cyc !== 1 || e !== 1'b0) begin
            errors++;
            $display("FAIL len0_write: done after %0d cycles err=%b required 1 and 0", cyc, e);
        end
        issue_cmd(1'b0, 32'h0000_1000, 16'd0);
        wait_done(e, cyc);
        checks++;
        if (cyc !== 1 || e !== 1'b0) begin
            errors++;
            $display("FAIL len0_read: done after %0d cycles err=%b required 1 and 0", cyc, e);
        end
        @(negedge clk);
        checks++;
        if (valid_cycles !== v0) begin
            errors++;
            $display("FAIL len0_no_axi: valid cycles %0d required %0d", valid_cycles, v0);
        end
    endtask

    task automatic test_aligned_write;
        logic e;
        int   cyc;
        int   b;
        b = aw_log.size();
        issue_cmd(1'b1, 32'h0000_1000, 16'd4);
        send_bytes(32'h4433_2211, 4);
        checks++;
        if (m_awvalid !== 1'b1 || m_wvalid !== 1'b1) begin
            errors++;
            $display("FAIL write_latency: awvalid=%b wvalid=%b required 1 1", m_awvalid, m_wvalid);
        end
        wait_done(e, cyc);
        checks++;
        if (aw_log.size() - b !== 1) begin
            errors++;
            $display("FAIL aligned_count: writes %0d required 1", aw_log.size() - b);
        end else begin
            checks++;
            if (aw_log[b] !== 32'h1000 || wd_log[b] !== 32'h4433_2211 || ws_log[b] !== 4'hF) begin
                errors++;
                $display("FAIL aligned_beat: addr %h data %h strb %b required 00001000 44332211 1111",
                         aw_log[b], wd_log[b], ws_log[b]);
            end
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL aligned_err: err=%b required 0", e);
        end
    endtask

    task automatic test_unaligned_write;
        logic        e;
        int          cyc;
        int          b;
        logic [31:0] xa[2];
        logic [31:0] xd[2];
        logic [3:0]  xs[2];
        xa = '{32'h4, 32'h8};
        xd = '{32'hBBAA_0000, 32'h0000_00CC};
        xs = '{4'b1100, 4'b0001};
        b = aw_log.size();
        issue_cmd(1'b1, 32'h0000_0006, 16'd3);
        send_bytes(32'h00CC_BBAA, 3);
        wait_done(e, cyc);
        checks++;
        if (aw_log.size() - b !== 2 || e !== 1'b0) begin
            errors++;
            $display("FAIL unaligned_count: writes %0d err=%b required 2 0", aw_log.size() - b, e);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (aw_log[b+i] !== xa[i] || wd_log[b+i] !== xd[i] || ws_log[b+i] !== xs[i]) begin
                    errors++;
                    $display("FAIL unaligned_beat%0d: addr %h data %h strb %b required %h %h %b",
                             i, aw_log[b+i], wd_log[b+i], ws_log[b+i], xa[i], xd[i], xs[i]);
                end
            end
        end
    endtask

    task automatic test_unaligned_read;
        logic [63:0] got;
        int          nb;
        logic        e;
        int          b;
        for (int pass = 0; pass < 2; pass++) begin
            b = ar_log.size();
            issue_cmd(1'b0, 32'h0000_1001, 16'd5);
            checks++;
            if (m_arvalid !== 1'b1) begin
                errors++;
                $display("FAIL read_latency: arvalid=%b required 1", m_arvalid);
            end
            read_bytes(pass == 1, got, nb, e);
            checks++;
            if (nb !== 5 || got !== 64'h0000_0066_5544_3322 || e !== 1'b0) begin
                errors++;
                $display("FAIL read_bytes pass%0d: %0d bytes %h err=%b required 5 0000006655443322 0",
                         pass, nb, got, e);
            end
            checks++;
            if (ar_log.size() - b !== 2) begin
                errors++;
                $display("FAIL read_ar_count pass%0d: %0d required 2", pass, ar_log.size() - b);
            end else begin
                checks++;
                if (ar_log[b] !== 32'h1000 || ar_log[b+1] !== 32'h1004) begin
                    errors++;
                    $display("FAIL read_araddr pass%0d: %h %h required 00001000 00001004",
                             pass, ar_log[b], ar_log[b+1]);
                end
            end
        end
    endtask

    task automatic test_skew_error;
        logic e;
        int   cyc;
        int   b;
        int   bw;
        aw_wait = 3; bresp_cfg = 2'b10;
        b  = aw_log.size();
        bw = wd_log.size();
        issue_cmd(1'b1, 32'h0000_0020, 16'd2);
        send_bytes(32'h0000_A55A, 2);
        wait_done(e, cyc);
        checks++;
        if (aw_log.size() - b !== 1 || wd_log.size() - bw !== 1) begin
            errors++;
            $display("FAIL skew_count: aw %0d w %0d required 1 1", aw_log.size() - b,
                     wd_log.size() - bw);
        end else begin
            checks++;
            if (aw_log[b] !== 32'h20 || wd_log[bw] !== 32'h0000_A55A || ws_log[bw] !== 4'b0011) begin
                errors++;
                $display("FAIL skew_beat: addr %h data %h strb %b required 00000020 0000a55a 0011",
                         aw_log[b], wd_log[bw], ws_log[bw]);
            end
        end
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL skew_err: err=%b required 1", e);
        end
        aw_wait = 0; bresp_cfg = 2'b00;
        b = aw_log.size();
        issue_cmd(1'b1, 32'h0000_0024, 16'd1);
        send_bytes(32'h0000_0077, 1);
        wait_done(e, cyc);
        checks++;
        if (e !== 1'b0 || aw_log.size() - b !== 1) begin
            errors++;
            $display("FAIL err_clears: err=%b writes %0d required 0 1", e, aw_log.size() - b);
        end else begin
            checks++;
            if (wd_log[b] !== 32'h77 || ws_log[b] !== 4'b0001) begin
                errors++;
                $display("FAIL single_byte: data %h strb %b required 00000077 0001",
                         wd_log[b], ws_log[b]);
            end
        end
    endtask

    task automatic test_wrap;
        logic        e;
        int          cyc;
        int          b;
        logic [31:0] xa[2];
        logic [31:0] xd[2];
        logic [3:0]  xs[2];
        xa = '{32'hFFFF_FFFC, 32'h0000_0000};
        xd = '{32'h0201_0000, 32'h0000_0403};
        xs = '{4'b1100, 4'b0011};
        b = aw_log.size();
        issue_cmd(1'b1, 32'hFFFF_FFFE, 16'd4);
        send_bytes(32'h0403_0201, 4);
        wait_done(e, cyc);
        checks++;
        if (aw_log.size() - b !== 2) begin
            errors++;
            $display("FAIL wrap_count: writes %0d required 2", aw_log.size() - b);
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (aw_log[b+i] !== xa[i] || wd_log[b+i] !== xd[i] || ws_log[b+i] !== xs[i]) begin
                    errors++;
                    $display("FAIL wrap_beat%0d: addr %h data %h strb %b required %h %h %b",
                             i, aw_log[b+i], wd_log[b+i], ws_log[b+i], xa[i], xd[i], xs[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic [63:0] got;
        int          nb;
        logic        e;
        int          b;
        ar_wait = 5;
        issue_cmd(1'b0, 32'h0000_1000, 16'd4);
        @(negedge clk);
        checks++;
        if (m_arvalid !== 1'b1) begin
            errors++;
            $display("FAIL mid_read_arvalid: arvalid=%b required 1", m_arvalid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({cmd_ready, wr_ready, rd_valid, done, err, m_awvalid, m_wvalid, m_bready,
             m_arvalid, m_rready} !== 10'b10_0000_0000) begin
            errors++;
            $display("FAIL mid_read_reset: got %b required 1000000000",
                     {cmd_ready, wr_ready, rd_valid, done, err, m_awvalid, m_wvalid,
                      m_bready, m_arvalid, m_rready});
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        ar_wait = 0;
        b = ar_log.size();
        issue_cmd(1'b0, 32'h0000_1000, 16'd4);
        read_bytes(1'b0, got, nb, e);
        checks++;
        if (nb !== 4 || got !== 64'h0000_0000_4433_2211 || e !== 1'b0 || ar_log.size() - b !== 1) begin
            errors++;
            $display("FAIL post_reset_read: %0d bytes %h err=%b ar %0d required 4 44332211 0 1",
                     nb, got, e, ar_log.size() - b);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0;
        bresp_cfg = 2'b00; rresp_cfg = 2'b00;
        reset_n = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

        test_reset;
        test_len_zero;
        test_aligned_write;
        test_unaligned_write;
        test_unaligned_read;
        test_skew_error;
        test_wrap;
        test_reset_mid_read;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
